// File: rtl/inst_axi_responder.sv
// Instruction-fetch responder: turns fetch requests into single-beat AXI reads.
// Optional perf counters: define INST_AXI_RESPONDER_PERFCNT_EN.
module inst_axi_responder #(
    parameter int         DEPTH  = 2,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_cache,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_data_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arcache,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
`ifdef INST_AXI_RESPONDER_PERFCNT_EN
    output logic [31:0] perfcnt_inst_lat,
    output logic [31:0] perfcnt_inst_req,
`endif
    output logic        rready
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic AR_IDLE = 1'b0;
    localparam logic AR_BUSY = 1'b1;

    logic          ar_state_q, ar_state_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [3:0]    arcache_q, arcache_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dok_q, dok_d;
    logic          derr_q, derr_d;
    logic [31:0]   drd_q, drd_d;

    logic accept;
    logic r_take;
    logic unused_rresp0;

    assign unused_rresp0 = rresp[0];

    // Constant AR attributes; data return never stalls.
    assign arid    = AXI_ID;
    assign arlen   = 8'd0;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign rready  = 1'b1;

    assign arvalid       = (ar_state_q == AR_BUSY);
    assign araddr        = araddr_q;
    assign arcache       = arcache_q;
    assign inst_data_ok  = dok_q;
    assign inst_data_err = derr_q;
    assign inst_rdata    = drd_q;

    // Accept only from registered state so arready/rvalid never reach addr_ok.
    assign accept       = inst_req && !arvalid && (cnt_q < CNT_MAX);
    assign inst_addr_ok = accept;

    // R beats with nothing outstanding are stale and get dropped.
    assign r_take = rvalid && rready && (cnt_q != '0);

    // AR channel FSM: latch the request, hold it until the handshake.
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        arcache_d  = arcache_q;
        case (ar_state_q)
            AR_IDLE: begin
                if (accept) begin
                    ar_state_d = AR_BUSY;
                    araddr_d   = inst_addr;
                    arcache_d  = inst_cache ? 4'b1111 : 4'b0000;
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    ar_state_d = AR_IDLE;
                end
            end
            default: ar_state_d = AR_IDLE;
        endcase
    end

    // Outstanding-read counter; simultaneous accept and return cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({accept, r_take})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Registered return path; rdata holds when nothing returns.
    always_comb begin
        dok_d  = r_take;
        derr_d = r_take && (rresp[1] || (rid != AXI_ID) || !rlast);
        drd_d  = r_take ? rdata : drd_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state_q <= AR_IDLE;
            araddr_q   <= '0;
            arcache_q  <= '0;
            cnt_q      <= '0;
            dok_q      <= 1'b0;
            derr_q     <= 1'b0;
            drd_q      <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            araddr_q   <= araddr_d;
            arcache_q  <= arcache_d;
            cnt_q      <= cnt_d;
            dok_q      <= dok_d;
            derr_q     <= derr_d;
            drd_q      <= drd_d;
        end
    end

`ifdef INST_AXI_RESPONDER_PERFCNT_EN
    logic [31:0] lat_q;
    logic [31:0] req_q;

    assign perfcnt_inst_lat = lat_q;
    assign perfcnt_inst_req = req_q;

    // Busy-cycle counter saturates; accept counter wraps.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lat_q <= '0;
            req_q <= '0;
        end else begin
            if ((cnt_q != '0) && (lat_q != 32'hFFFF_FFFF)) begin
                lat_q <= lat_q + 32'd1;
            end
            if (accept) begin
                req_q <= req_q + 32'd1;
            end
        end
    end
`endif

endmodule
